req_ack_initiator: RTL
======================

# req_ack_initiator

Requester-side counterpart of the team's req/ack handshake responder. Accepts payload words from a local valid/ready source and buffers them in a small FIFO. Presents each word on `req_data` and runs the handshake against a responder: four-phase level handshake (STREAM_MODE=0) or per-cycle streaming (STREAM_MODE>0). A per-transaction timeout drops words the responder never acknowledges.

## Interface
- `DATA_W`, 32: payload width.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `STREAM_MODE`, 0: 0 = four-phase level handshake; >0 = streaming, one word per cycle with `req & ack`.
- `TIMEOUT`, 0: cycles to wait for ack before dropping the head word; 0 disables the timeout.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  local source has a word.
- `cmd_ready`  out  1  FIFO can accept; equals `count < FIFO_DEPTH`.
- `cmd_data`  in  DATA_W  word to send.
- `req`  out  1  request to the responder.
- `req_data`  out  DATA_W  FIFO head word; valid whenever `req`=1.
- `ack`  in  1  acknowledge from the responder.
- `done_pulse`  out  1  one-cycle pulse per acknowledged word.
- `timeout_pulse`  out  1  one-cycle pulse per dropped word.
- `busy`  out  1  FIFO non-empty or handshake in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO push on `cmd_valid & cmd_ready`. Pop on handshake completion or timeout. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- `req_data` = FIFO head, combinational from the read pointer.
- Level mode FSM, states IDLE, REQ, WAIT_LOW:
  - IDLE: if `fifo_count`≠0, go to REQ.
  - REQ: `req`=1. If `ack`=1, pop, pulse `done_pulse`, go to WAIT_LOW. Else if the timeout counter reaches TIMEOUT, pop, pulse `timeout_pulse`, go to WAIT_LOW.
  - WAIT_LOW: `req`=0. When `ack`=0: go to REQ if `fifo_count`≠0 after any same-cycle push; otherwise go to IDLE.
- `req` is registered and equals (state==REQ). Head and `req_data` do not change while `req`=1.
- Streaming mode (FSM unused):
  - `req` = FIFO non-empty, combinational.
  - Pop each cycle `req & ack`=1; `done_pulse` is registered, one cycle later.
  - The timeout counter counts consecutive `req & ~ack` cycles. On reaching TIMEOUT: pop and pulse `timeout_pulse`.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to REQ (level mode) or on any pop (streaming mode).
  - Saturates, never wraps.
  - Ack in the same cycle the counter reaches TIMEOUT counts as success: `done_pulse` fires, not `timeout_pulse`.
- `busy` = (`fifo_count`≠0) | (state≠IDLE).

## Timing
- Reset: async clear of pointers, count, FSM (to IDLE) and timeout counter.
  - `req`, `done_pulse`, `timeout_pulse` and `busy` are 0 during reset; `cmd_ready` is 1.
  - `req_data` is don't-care (memory not cleared).
  - Reset mid-handshake drops `req` immediately and discards all buffered words.
- Level mode, word written at edge E0 with the FSM idle:
  - E1: `req`=1.
  - Against a responder that registers ack one cycle after req: ack high after E2; sampled at E3, giving pop and `done_pulse`=1 for the cycle after E3, with `req`=0.
  - Ack low after E4; FSM leaves WAIT_LOW at E5.
  - Back-to-back words: `req` rises again at E5. Period is 4 cycles.
- Streaming mode: word written at E0 gives `req`=1 after E0. With `ack` held high, throughput is one word per cycle.
- A full FIFO holds `cmd_ready`=0. A pop while full raises `cmd_ready` the following cycle (registered count).
- `ack`=1 while in IDLE or WAIT_LOW is ignored, except that WAIT_LOW keeps waiting for `ack`=0.

## Test plan
- Level mode, single word 0xA5A5_0001, 4-phase responder model → `req` high for 2 cycles. `req_data`=0xA5A5_0001 while `req`=1. Exactly one `done_pulse`. `fifo_count` returns to 0 and `busy`=0 by E6.
- Level mode: push 5 words with the responder held off (`req_en`=0) → `cmd_ready`=0 after the 4th; the 5th is accepted after the first completion. All 5 are delivered in order with a 4-cycle period once the responder is enabled.
- TIMEOUT=8, responder never acks → `req` high exactly 8 cycles, one `timeout_pulse`, word dropped. The next word is presented after `ack` is seen low.
- Streaming mode: 3 words 1, 2, 3 with `ack` tied to `req` → pops on 3 consecutive cycles, 3 `done_pulse`s each one cycle after its pop, `req`=0 on the 4th cycle.
- Simultaneous push and pop at `fifo_count`=2 → count stays 2 and order is preserved. Pointer wrap is checked over 10 words with FIFO_DEPTH=4.
- `rstn` asserted while `req`=1 with 3 words buffered → `req`, `busy` and `fifo_count` go to 0 without a clock edge. After release, no `req` until a new push.

Source files
------------

// File: rtl/req_ack_initiator.sv
// req_ack_initiator: FIFO-buffered requester driving a four-phase or streaming req/ack handshake,
// with an optional per-word ack timeout that drops unacknowledged words.
module req_ack_initiator #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int STREAM_MODE = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic                          req,
  output logic [DATA_W-1:0]             req_data,
  input  logic                          ack,
  output logic                          done_pulse,
  output logic                          timeout_pulse,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int TL = TIMEOUT > 0 ? TIMEOUT - 1 : 0;
  localparam logic [AW:0]   FULL   = FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0] T_LAST = TL[TW-1:0];
  localparam logic [TW-1:0] T_MAX  = TIMEOUT[TW-1:0];

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              req_q, done_q, tout_q;
  logic              push, pop, tmo_hit;

  assign cmd_ready     = cnt_q != FULL;
  assign push          = cmd_valid && cmd_ready;
  assign req           = STREAM_MODE > 0 ? cnt_q != '0 : req_q;
  assign req_data      = mem_q[rd_q];
  // The cycle that would make the count reach TIMEOUT is the last one; ack wins over it.
  assign tmo_hit       = TIMEOUT > 0 && tmo_q == T_LAST;
  assign pop           = req && (ack || tmo_hit);
  assign cnt_d         = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign tmo_d         = (!req || pop) ? '0 : (tmo_q != T_MAX ? tmo_q + 1'b1 : tmo_q);
  assign done_pulse    = done_q;
  assign timeout_pulse = tout_q;
  assign busy          = cnt_q != '0 || state_q != IDLE;
  assign fifo_count    = cnt_q;

  always_comb begin
    state_d = STREAM_MODE > 0 ? IDLE :
              state_q == IDLE ? (cnt_q != '0 ? REQ : IDLE) :
              state_q == REQ  ? (pop ? WAIT_LOW : REQ) :
              ack             ? WAIT_LOW :
              cnt_d != '0     ? REQ : IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      tmo_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= state_d == REQ;
      done_q  <= req && ack;
      tout_q  <= req && !ack && tmo_hit;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cmd_data;
  end
endmodule
